// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array feeder.
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WLOAD  = 3'd1,
        ST_WSHIFT = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4
    } feeder_state_t;

    // Zero cycles needed after the last activation row before the wavefront has left the array.
    function automatic int drain_cycles(input int n);
        return (32'sd2 * n) - 32'sd1;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(32'sd2 * n);
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth delay line for one activation lane; DEPTH = 0 is a plain wire.
module skew_delay_line #(
    parameter int DEPTH     = 1,
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_SIZE-1:0] i_data,
    output logic [DATA_SIZE-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_ctrl;
            assign w_unused_ctrl = clk ^ rst_n;
            assign o_data        = i_data;
        end else begin : g_shift
            logic [DATA_SIZE-1:0] r_taps [DEPTH];

            // Shift the lane one tap per cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        r_taps[k] <= '0;
                    end
                end else begin
                    r_taps[0] <= i_data;
                    for (int k = 1; k < DEPTH; k++) begin
                        r_taps[k] <= r_taps[k-1];
                    end
                end
            end

            assign o_data = r_taps[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// Drives the systolic array: buffers one weight matrix, shifts it in bottom row first,
// then streams diagonally skewed activation rows and flushes the wavefront with zeros.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  keep_weights,
    input  logic                                  w_valid,
    output logic                                  w_ready,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] w_row,
    input  logic                                  a_valid,
    output logic                                  a_ready,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] a_row,
    input  logic                                  a_last,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] in_data,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] in_weights,
    output logic                                  ld_weight,
    output logic                                  busy,
    output logic                                  done
);

    localparam int N  = MATRIX_SIZE;
    localparam int CW = cnt_width(MATRIX_SIZE);
    localparam logic [CW-1:0] ROW_LAST   = CW'(N - 32'sd1);
    localparam logic [CW-1:0] ROW_PRE    = CW'(N - 32'sd2);
    localparam logic [CW-1:0] DONE_ARM   = CW'(drain_cycles(N) - 32'sd1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(drain_cycles(N));

    feeder_state_t                   r_state;
    feeder_state_t                   w_state_nxt;
    logic [CW-1:0]                   r_cnt;
    logic [CW-1:0]                   w_cnt_nxt;
    logic [N-1:0][DATA_SIZE-1:0]     r_w_buf [N];
    logic [N-1:0][DATA_SIZE-1:0]     w_rd_row;
    logic [N-1:0][DATA_SIZE-1:0]     w_in_weights_nxt;
    logic [N-1:0][DATA_SIZE-1:0]     w_lane_in;
    logic [N-1:0][DATA_SIZE-1:0]     w_lane_out;
    logic [N-1:0][DATA_SIZE-1:0]     r_in_data;
    logic [N-1:0][DATA_SIZE-1:0]     r_in_weights;
    logic                            r_w_ready;
    logic                            r_a_ready;
    logic                            r_ld_weight;
    logic                            r_busy;
    logic                            r_done;
    logic                            w_w_hs;
    logic                            w_a_hs;

    assign w_w_hs    = w_valid & r_w_ready;
    assign w_a_hs    = a_valid & r_a_ready;
    assign w_lane_in = w_a_hs ? a_row : '0;

    // Row of the weight buffer presented in the next shift cycle (OR-mux over rows).
    always_comb begin
        w_rd_row = '0;
        for (int j = 0; j < N; j++) begin
            w_rd_row = w_rd_row | ((CW'(j) == (ROW_PRE - r_cnt)) ? r_w_buf[j] : '0);
        end
    end

    // Next state, phase counter and next weight-bus value.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_in_weights_nxt = '0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (start && keep_weights) begin
                    w_state_nxt = ST_STREAM;
                end else if (start) begin
                    w_state_nxt = ST_WLOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WLOAD: begin
                // The final row goes straight onto the bus while it is being stored.
                if (w_w_hs && (r_cnt == ROW_LAST)) begin
                    w_state_nxt      = ST_WSHIFT;
                    w_cnt_nxt        = '0;
                    w_in_weights_nxt = w_row;
                end else if (w_w_hs) begin
                    w_cnt_nxt = r_cnt + CW'(1'b1);
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_WSHIFT: begin
                if (r_cnt == ROW_LAST) begin
                    w_state_nxt = ST_STREAM;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt        = r_cnt + CW'(1'b1);
                    w_in_weights_nxt = w_rd_row;
                end
            end
            ST_STREAM: begin
                if (w_a_hs && a_last) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == DRAIN_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1'b1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter, registered handshake/status flags and array-facing buses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_w_ready    <= 1'b0;
            r_a_ready    <= 1'b0;
            r_ld_weight  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_in_weights <= '0;
            r_in_data    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_w_ready    <= (w_state_nxt == ST_WLOAD);
            r_a_ready    <= (w_state_nxt == ST_STREAM);
            r_ld_weight  <= (w_state_nxt == ST_WSHIFT);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_done       <= (r_state == ST_DRAIN) && (r_cnt == DONE_ARM);
            r_in_weights <= w_in_weights_nxt;
            r_in_data    <= w_lane_out;
        end
    end

    // Weight buffer capture, one row per accepted handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < N; j++) begin
                r_w_buf[j] <= '0;
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                if (w_w_hs && (r_cnt == CW'(j))) begin
                    r_w_buf[j] <= w_row;
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < N; i++) begin : g_lane
            skew_delay_line #(
                .DEPTH     (i),
                .DATA_SIZE (DATA_SIZE)
            ) u_skew (
                .clk    (clk),
                .rst_n  (reset),
                .i_data (w_lane_in[i]),
                .o_data (w_lane_out[i])
            );
        end
    endgenerate

    assign w_ready    = r_w_ready;
    assign a_ready    = r_a_ready;
    assign ld_weight  = r_ld_weight;
    assign busy       = r_busy;
    assign done       = r_done;
    assign in_data    = r_in_data;
    assign in_weights = r_in_weights;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench: random jobs against a cycle-indexed timeline built from the feeder's timing rules.
module tb_systolic_feeder;

    localparam int N    = 3;
    localparam int DW   = 32;
    localparam int MAXC = 2048;
    localparam int BIG  = 1000000;

    typedef logic [N-1:0][DW-1:0] row_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic keep_weights;
    logic w_valid;
    logic w_ready;
    row_t w_row;
    logic a_valid;
    logic a_ready;
    row_t a_row;
    logic a_last;
    row_t in_data;
    row_t in_weights;
    logic ld_weight;
    logic busy;
    logic done;

    int cyc       = 0;
    int n_asserts = 0;
    int n_fail    = 0;

    row_t exp_data [MAXC];
    row_t exp_w    [MAXC];
    logic exp_ld   [MAXC];
    logic exp_done [MAXC];
    int   busy_from, busy_to, wr_from, wr_to, ar_from, ar_to;

    systolic_feeder #(.MATRIX_SIZE(N), .DATA_SIZE(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .keep_weights (keep_weights),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_row        (w_row),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_row        (a_row),
        .a_last       (a_last),
        .in_data      (in_data),
        .in_weights   (in_weights),
        .ld_weight    (ld_weight),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < N; i++) r[i] = $urandom;
        return r;
    endfunction

    function automatic logic in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    task automatic chk_row(input string tag, input row_t obs, input row_t expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_cycle();
        int c;
        c = cyc;
        chk_row("in_data",    in_data,    exp_data[c]);
        chk_row("in_weights", in_weights, exp_w[c]);
        chk_bit("ld_weight",  ld_weight,  exp_ld[c]);
        chk_bit("done",       done,       exp_done[c]);
        chk_bit("busy",       busy,       in_rng(c, busy_from, busy_to));
        chk_bit("w_ready",    w_ready,    in_rng(c, wr_from, wr_to));
        chk_bit("a_ready",    a_ready,    in_rng(c, ar_from, ar_to));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic clear_model(input int from);
        for (int x = from; x < MAXC; x++) begin
            exp_data[x] = '0;
            exp_w[x]    = '0;
            exp_ld[x]   = 1'b0;
            exp_done[x] = 1'b0;
        end
        busy_from = BIG; busy_to = -1;
        wr_from   = BIG; wr_to   = -1;
        ar_from   = BIG; ar_to   = -1;
    endtask

    // Random values on every input a busy feeder must ignore.
    task automatic drive_noise();
        start        = 1'($urandom_range(1));
        keep_weights = 1'($urandom_range(1));
        w_valid      = 1'($urandom_range(1));
        w_row        = rand_row();
        a_valid      = 1'($urandom_range(1));
        a_row        = rand_row();
        a_last       = 1'($urandom_range(1));
    endtask

    task automatic drive_quiet();
        start = 1'b0; keep_weights = 1'b0; w_valid = 1'b0; a_valid = 1'b0; a_last = 1'b0;
        w_row = '0; a_row = '0;
    endtask

    // One job from an IDLE cycle; abort_after >= 0 pulls reset after that many activation rows.
    task automatic run_job(input bit keep, input int n_rows, input int gap_pct, input int abort_after);
        row_t wb [N];
        int   c, k, r, tries;
        drive_quiet();
        c = cyc;
        start = 1'b1; keep_weights = keep;
        busy_from = c + 1; busy_to = BIG;
        if (keep) begin ar_from = c + 1; ar_to = BIG; end
        else begin wr_from = c + 1; wr_to = BIG; end
        step();
        if (!keep) begin
            k = 0; tries = 0;
            while (k < N) begin
                c = cyc;
                drive_noise();
                w_valid = (tries >= 20) || ($urandom_range(99) >= gap_pct);
                if (w_valid) begin
                    wb[k] = w_row; k++; tries = 0;
                    if (k == N) begin
                        wr_to = c;
                        for (int j = 0; j < N; j++) begin
                            exp_ld[c+1+j] = 1'b1;
                            exp_w[c+1+j]  = wb[N-1-j];
                        end
                        ar_from = c + N + 1; ar_to = BIG;
                    end
                end else begin
                    tries++;
                end
                step();
            end
            while (cyc < ar_from) begin
                drive_noise();
                step();
            end
        end
        r = 0; tries = 0;
        while (r < n_rows) begin
            c = cyc;
            drive_noise();
            a_valid = (tries >= 20) || ($urandom_range(99) >= gap_pct);
            if (a_valid) begin
                a_last = (r == n_rows - 1) && (abort_after < 0);
                for (int i = 0; i < N; i++) exp_data[c+1+i][i] = a_row[i];
                r++; tries = 0;
                if (a_last) begin
                    ar_to = c; busy_to = c + 2*N; exp_done[c+2*N] = 1'b1;
                end
            end else begin
                tries++;
            end
            step();
            if ((abort_after >= 0) && (r == abort_after)) begin
                #2;
                reset = 1'b0;
                #1;
                clear_model(cyc);
                check_cycle();
                drive_quiet();
                step();
                step();
                reset = 1'b1;
                step();
                return;
            end
        end
        while (cyc <= busy_to) begin
            drive_noise();
            step();
        end
        drive_quiet();
    endtask

    initial begin
        reset = 1'b0;
        drive_quiet();
        clear_model(0);
        repeat (3) step();
        reset = 1'b1;
        step();

        run_job(1'b0, 4, 0,  -1);
        run_job(1'b0, 5, 40, -1);
        run_job(1'b1, 3, 20, -1);
        run_job(1'b0, 1, 0,  -1);
        run_job(1'b1, 6, 30, 3);
        run_job(1'b0, 4, 25, -1);
        for (int j = 0; j < 4; j++) begin
            run_job(1'($urandom_range(1)), int'($urandom_range(6, 1)), int'($urandom_range(50)), -1);
        end
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Front-end driver for the `matrix_multiply` systolic array, which consumes `in_data`, `in_weights` and `ld_weight`. The feeder buffers one MATRIX_SIZE×MATRIX_SIZE weight matrix, shifts it into the array in reverse row order with `ld_weight` asserted, then streams activation rows with per-lane diagonal skew. It finishes by flushing zeros until the wavefront has left the array. It sits between the host-side row streams and the array inputs.

## Interface
- MATRIX_SIZE, 2, array dimension N (N ≥ 2)
- DATA_SIZE, 32, element width in bits

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state
- start  in  1  begin a job; sampled only in IDLE
- keep_weights  in  1  with start: skip weight load, reuse array contents
- w_valid  in  1  weight row valid
- w_ready  out  1  weight row accepted when w_valid & w_ready
- w_row  in  [DATA_SIZE-1:0] ×N  weight row, element j → column j
- a_valid  in  1  activation row valid
- a_ready  out  1  activation handshake
- a_row  in  [DATA_SIZE-1:0] ×N  activation row, element i → array row i
- a_last  in  1  marks final activation row of job
- in_data  out  [DATA_SIZE-1:0] ×N  to array, skewed
- in_weights  out  [DATA_SIZE-1:0] ×N  to array column tops
- ld_weight  out  1  to array, weight shift enable
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at job end

## Operation
- States: IDLE, WLOAD, WSHIFT, STREAM, DRAIN.
- IDLE: w_ready = a_ready = 0.
  - start & !keep_weights → WLOAD.
  - start & keep_weights → STREAM.
- WLOAD:
  - w_ready = 1.
  - Each handshake stores w_row into w_buf[k], where k counts 0..N-1.
  - After the N-th handshake → WSHIFT.
- WSHIFT: lasts exactly N cycles. In cycle c:
  - ld_weight = 1.
  - in_weights = w_buf[N-1-c], so row 0 ends at the top and row N-1 at the bottom.
  - in_data = 0.
  - Then → STREAM.
- STREAM:
  - a_ready = 1 and in_weights = 0.
  - Every cycle the skew pipeline advances.
  - Lane i input = a_row[i] if the handshake occurs, else 0 (bubble).
  - Handshake with a_last → DRAIN.
- DRAIN:
  - Lane inputs = 0 for exactly 2N-1 cycles, then done = 1 for one cycle → IDLE.
- start is ignored outside IDLE. w_valid/a_valid are ignored whenever the matching ready is 0.
- Skew: lane i is a shift register of depth i, so lane 0 has no extra delay.
- Data is passed through unmodified, with no arithmetic on values.
- Asynchronous reset mid-job:
  - Immediate return to IDLE.
  - w_buf, skew registers and counters cleared.
  - The job is lost; no done.

## Timing
- Reset values: w_ready = a_ready = ld_weight = busy = done = 0; in_data = in_weights = all zeros.
- All array-facing outputs and done are registered.
- start accepted at edge t → busy = 1 from t+1. w_ready (or a_ready when keep_weights = 1) is also 1 from t+1.
- Last weight handshake at edge t → ld_weight = 1 for cycles t+1..t+N.
- Activation handshake at edge t → element i appears on in_data[i] during cycle t+1+i.
- a_last at edge t → last element reaches lane N-1 at t+N. done is asserted during cycle t+2N, busy falls the same edge done falls.
- Back-to-back jobs: start may be asserted in the cycle after done. There are no idle cycles between jobs beyond IDLE's one cycle.

## Structure
- Package `systolic_pkg`: state enum `feeder_state_t`, localparam function `drain_cycles(N) = 2N-1`, counter width `$clog2(2N)`.
- Sub-module `skew_delay_line` (parameters DEPTH, DATA_SIZE):
  - Async active-low clear.
  - DEPTH = 0 is a register-free pass-through.
  - The feeder generates one instance per lane with DEPTH = i.
  - The output register is common to all lanes.

## Test plan
- N=2, weight rows [1,2],[3,4] → WSHIFT cycles: in_weights = [3,4] then [1,2], ld_weight high exactly 2 cycles, in_data = 0.
- N=2, activation rows [5,6],[7,8] back-to-back, second with a_last → in_data[0] = 5,7,0…; in_data[1] = 0,6,8,0…; done 4 cycles after the a_last edge.
- N=3, a_valid low one cycle between rows → zero bubble is visible diagonally on lanes 0..2 at consecutive cycles.
- start with keep_weights = 1 → no ld_weight pulse, a_ready = 1 on the next cycle.
- reset = 0 asserted mid-STREAM → all outputs zero immediately, busy = 0, no done. A new job afterward behaves identically to a fresh one.
- start asserted during busy, and w_valid held during STREAM → both ignored, with no extra weight stored.
